// File: rtl/dev_button.sv
// Push-button input device: two-flop synchroniser, debounce, press/release/long-press
// detection and a single-entry event register. Define DEV_BUTTON_REPEAT_EN for long-press auto-repeat.
module dev_button #(
    parameter int unsigned CLK_FREQ   = 12_000_000,
    parameter int unsigned DEBOUNCE   = CLK_FREQ / 100,
    parameter int unsigned LONG       = CLK_FREQ,
    parameter int unsigned REPEAT     = CLK_FREQ / 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pin,
    output logic       level,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    input  logic       ev_ack,
    output logic       overflow
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
    localparam int unsigned HOLD_W = $clog2(LONG + 1);

    localparam logic [1:0] EV_NONE    = 2'd0;
    localparam logic [1:0] EV_PRESS   = 2'd1;
    localparam logic [1:0] EV_RELEASE = 2'd2;
    localparam logic [1:0] EV_LONG    = 2'd3;

    if (CLK_FREQ == 0 || DEBOUNCE == 0 || LONG < 2 || REPEAT == 0) begin : g_param_check
        $error("dev_button: CLK_FREQ, DEBOUNCE and REPEAT must be nonzero and LONG at least 2");
    end

    logic              sync_q1;
    logic              sync_q2;
    logic              raw_c;
    logic [DB_W-1:0]   db_cnt;
    logic              level_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_c;
    logic [1:0]        ev_new_c;
    logic              have_c;

    // Synchroniser idles at the released pin value so a held button still reads as a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= ACTIVE_LOW;
            sync_q2 <= ACTIVE_LOW;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
        end
    end

    assign raw_c = sync_q2 ^ ACTIVE_LOW;

    // Accept a new level only after DEBOUNCE consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (raw_c == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
            db_cnt <= '0;
            level  <= raw_c;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Saturating press duration; passes LONG-1 exactly once per press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            level_q <= level;
            if (!level) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_W'(LONG)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

`ifdef DEV_BUTTON_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_fire_c;

    assign rep_fire_c = level && (hold_cnt == HOLD_W'(LONG)) && (rep_cnt == REP_W'(REPEAT - 1));

    // Repeat period starts once the hold counter has saturated, i.e. the cycle after the first LONG
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (!level || hold_cnt != HOLD_W'(LONG) || rep_fire_c) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end

    assign long_c = (level && (hold_cnt == HOLD_W'(LONG - 1))) || rep_fire_c;
`else
    assign long_c = level && (hold_cnt == HOLD_W'(LONG - 1));
`endif

    // Release has priority over a coincident long-press
    always_comb begin
        ev_new_c = EV_NONE;
        if (!level && level_q) begin
            ev_new_c = EV_RELEASE;
        end else if (level && !level_q) begin
            ev_new_c = EV_PRESS;
        end else if (long_c) begin
            ev_new_c = EV_LONG;
        end
    end

    assign have_c = (ev_new_c != EV_NONE);

    // Single pending event; a new event while one is unacknowledged is dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid <= 1'b0;
            ev_code  <= EV_NONE;
            overflow <= 1'b0;
        end else begin
            if (have_c && (!ev_valid || ev_ack)) begin
                ev_valid <= 1'b1;
                ev_code  <= ev_new_c;
            end else if (ev_ack) begin
                ev_valid <= 1'b0;
                ev_code  <= EV_NONE;
            end

            if (have_c && ev_valid && !ev_ack) begin
                overflow <= 1'b1;
            end else if (ev_ack && ev_valid) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dev_button.sv
// Testbench for dev_button: directed vector table, hand-written reset/event-order sequences,
// and randomized pin/ack traffic checked against a behavioural model.
module tb_dev_button;

    localparam int unsigned DB = 4;
    localparam int unsigned LG = 20;
    localparam int unsigned RP = 8;
    localparam bit          AL = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin = 1'b1;
    logic       ev_ack = 1'b0;
    logic       level;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;
    bit mdl_on = 1'b0;

    dev_button #(
        .CLK_FREQ  (1000),
        .DEBOUNCE  (DB),
        .LONG      (LG),
        .REPEAT    (RP),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin     (pin),
        .level   (level),
        .ev_valid(ev_valid),
        .ev_code (ev_code),
        .ev_ack  (ev_ack),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: pin delay line, window of recent raw samples, unsaturated press age
    bit m_p0 = AL, m_p1 = AL;
    bit m_win[$];
    bit m_level = 0, m_prev = 0;
    int m_age = 0;
    bit m_v = 0, m_ov = 0;
    int m_code = 0;

    always @(posedge clk or negedge rst_n) begin
        int  ncode;
        bit  flip;
        bit  raw;
        bit  old_v;
        if (!rst_n) begin
            m_p0 = AL; m_p1 = AL; m_win.delete();
            m_level = 0; m_prev = 0; m_age = 0;
            m_v = 0; m_code = 0; m_ov = 0;
        end else begin
            ncode = 0;
            if (!m_level && m_prev) ncode = 2;
            else if (m_level && !m_prev) ncode = 1;
            else if (m_level && m_age == int'(LG) - 1) ncode = 3;
`ifdef DEV_BUTTON_REPEAT_EN
            else if (m_level && m_age > int'(LG) - 1 && (m_age - (int'(LG) - 1)) % int'(RP) == 0) ncode = 3;
`endif
            old_v = m_v;
            if (ncode != 0 && old_v && !ev_ack) m_ov = 1;
            else if (ev_ack && old_v) m_ov = 0;
            if (ncode != 0 && (!old_v || ev_ack)) begin m_v = 1; m_code = ncode; end
            else if (ev_ack) begin m_v = 0; m_code = 0; end

            raw = m_p1 ^ AL;
            m_win.push_back(raw);
            if (m_win.size() > int'(DB)) void'(m_win.pop_front());
            flip = (m_win.size() == int'(DB));
            foreach (m_win[i]) if (m_win[i] == m_level) flip = 0;

            m_age  = m_level ? m_age + 1 : 0;
            m_prev = m_level;
            if (flip) m_level = !m_level;
            m_p1 = m_p0;
            m_p0 = pin;
        end
    end

    always @(negedge clk) begin
        if (mdl_on && rst_n === 1'b1)
            chk("model", {3'b0, level, ev_valid, ev_code, overflow},
                {3'b0, m_level, m_v, 2'(m_code), m_ov});
    end

    typedef struct packed {
        logic        pin;
        logic        ack;
        int unsigned n;
        logic        lvl;
        logic        vld;
        logic [1:0]  code;
        logic        ov;
    } vec_t;

    vec_t tbl [20];
    int   ev_at[$];
    int   ev_cd[$];
    int   exp_at[$];
    int   exp_cd[$];

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},    {7'b0, level},    8'd0);
        chk({tag, "_valid"},    {7'b0, ev_valid}, 8'd0);
        chk({tag, "_code"},     {6'b0, ev_code},  8'd0);
        chk({tag, "_overflow"}, {7'b0, overflow}, 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            pin   ack   n    lvl   vld   code  ov
        tbl[0]  = '{1'b1, 1'b0,  3, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0,  5, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 17, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 2'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0,  5, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[11] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 1'b0,  3, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 1'b0,  7, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 19, 1'b1, 1'b1, 2'd1, 1'b1};
        tbl[16] = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[17] = '{1'b1, 1'b0,  6, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[19] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 2'd0, 1'b0};

        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst_n  = 1'b1;
        mdl_on = 1'b1;

        // Directed vectors: each row drives pin/ack for n cycles, then checks outputs
        for (int i = 0; i < 20; i++) begin
            pin    = tbl[i].pin;
            ev_ack = tbl[i].ack;
            repeat (tbl[i].n) @(negedge clk);
            chk($sformatf("tbl%0d_level", i), {7'b0, level},    {7'b0, tbl[i].lvl});
            chk($sformatf("tbl%0d_valid", i), {7'b0, ev_valid}, {7'b0, tbl[i].vld});
            chk($sformatf("tbl%0d_code", i),  {6'b0, ev_code},  {6'b0, tbl[i].code});
            chk($sformatf("tbl%0d_ovf", i),   {7'b0, overflow}, {7'b0, tbl[i].ov});
        end

        // Asynchronous reset mid-hold with an event pending, button still held afterwards
        pin = 1'b0; ev_ack = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_valid", {7'b0, ev_valid}, 8'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_level", {7'b0, level},    8'd1);
        chk("post_rst_idle",  {7'b0, ev_valid}, 8'd0);
        @(negedge clk);
        chk("post_rst_valid", {7'b0, ev_valid}, 8'd1);
        chk("post_rst_code",  {6'b0, ev_code},  8'd1);
        pin = 1'b1; ev_ack = 1'b1;
        repeat (12) @(negedge clk);
        ev_ack = 1'b0;
        chk_all_zero("drained");

        // Event order over a long hold, acking every event the cycle after it appears
        exp_at = '{7, 26};
        exp_cd = '{1, 3};
`ifdef DEV_BUTTON_REPEAT_EN
        exp_at = '{7, 26, 34, 42, 50};
        exp_cd = '{1, 3, 3, 3, 3};
`endif
        exp_at.push_back(57);
        exp_cd.push_back(2);
        pin = 1'b0;
        for (int e = 1; e <= 70; e++) begin
            @(negedge clk);
            if (ev_valid) begin
                ev_at.push_back(e);
                ev_cd.push_back(int'(ev_code));
            end
            ev_ack = ev_valid;
            if (e == 50) pin = 1'b1;
        end
        ev_ack = 1'b0;
        chk("seq_count", 8'(ev_at.size()), 8'(exp_at.size()));
        for (int i = 0; i < exp_at.size(); i++) begin
            chk($sformatf("seq%0d_cycle", i), (i < ev_at.size()) ? 8'(ev_at[i]) : 8'hff, 8'(exp_at[i]));
            chk($sformatf("seq%0d_code", i),  (i < ev_cd.size()) ? 8'(ev_cd[i]) : 8'hff, 8'(exp_cd[i]));
        end

        // Randomized pin and ack traffic, with one asynchronous reset partway through
        for (int k = 0; k < 120; k++) begin
            int dur;
            dur = (k % 3 == 0) ? $urandom_range(1, 6) : $urandom_range(1, 45);
            pin = 1'($urandom_range(0, 1));
            repeat (dur) begin
                ev_ack = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            if (k == 60) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
